// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port async SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RECOVER
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
  } cmd_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select for the SRAM arbiter.
// SRAM_ARB_RR_EN selects round-robin via ptr_i; otherwise port 0 has fixed priority.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef SRAM_ARB_RR_EN
  input  logic       ptr_i,
`endif
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o = |req_i;
`ifdef SRAM_ARB_RR_EN
    if (req_i[PORT_CPU] && req_i[PORT_DMA]) begin
      winner_o = ptr_i;
    end else begin
      winner_o = req_i[PORT_DMA] ? PORT_DMA : PORT_CPU;
    end
`else
    winner_o = req_i[PORT_CPU] ? PORT_CPU : PORT_DMA;
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter sequencing fixed-timing reads/writes to an async 16-bit SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0).
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = sram_arb_pkg::ADDR_W,
  parameter int DATA_W      = sram_arb_pkg::DATA_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [3:0]          be,
  output logic [1:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                gnt_id,
  output logic                CE,
  output logic                UB,
  output logic                LB,
  output logic                OE,
  output logic                WE,
  output logic [ADDR_W-1:0]   ADDR,
  inout  wire  [DATA_W-1:0]   Data
);

  import sram_arb_pkg::*;

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("sram_arbiter: WAIT_CYCLES must be >= 1");
  end
  if (ADDR_W != sram_arb_pkg::ADDR_W || DATA_W != sram_arb_pkg::DATA_W) begin : g_bad_width
    $error("sram_arbiter: ADDR_W/DATA_W must match the latched command type");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  cmd_t               cmd_q, cmd_d;
  cmd_t               sel_cmd;
  logic               gnt_q, gnt_d;
  logic               ce_q, ce_d;
  logic               oe_q, oe_d;
  logic               wen_q, wen_d;
  logic               ub_q, ub_d;
  logic               lb_q, lb_d;
  logic               doe_q, doe_d;
  logic [1:0]         ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               pick_valid;
  logic               pick_winner;

`ifdef SRAM_ARB_RR_EN
  logic               ptr_q, ptr_d;

  sram_arb_pick u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );
`else
  sram_arb_pick u_pick (
    .req_i    (req),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );
`endif

  always_comb begin
    sel_cmd.we    = we[pick_winner];
    sel_cmd.addr  = pick_winner ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
    sel_cmd.wdata = pick_winner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    sel_cmd.be    = pick_winner ? be[3:2] : be[1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pick_valid) state_d = sel_cmd.we ? WR_SETUP : READ;
      READ:     if (cnt_q == '0) state_d = RECOVER;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD;
      WR_HOLD:  state_d = RECOVER;
      RECOVER:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Every pin-facing signal is computed one cycle ahead so the pins come straight off flops.
  always_comb begin
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    gnt_d   = gnt_q;
    ce_d    = ce_q;
    oe_d    = oe_q;
    wen_d   = wen_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    doe_d   = doe_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    busy_d  = (state_d != IDLE);
`ifdef SRAM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          cmd_d = sel_cmd;
          gnt_d = pick_winner;
          cnt_d = CNT_LOAD;
          ce_d  = 1'b0;
          ub_d  = ~sel_cmd.be[1];
          lb_d  = ~sel_cmd.be[0];
          oe_d  = sel_cmd.we;
          doe_d = sel_cmd.we;
`ifdef SRAM_ARB_RR_EN
          ptr_d = ~pick_winner;
`endif
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          if (!cmd_q.we) rdata_d = Data;
          ack_d[gnt_q] = 1'b1;
          ce_d = 1'b1;
          oe_d = 1'b1;
          ub_d = 1'b1;
          lb_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_SETUP: begin
        wen_d = 1'b0;
        ub_d  = ~cmd_q.be[1];
        lb_d  = ~cmd_q.be[0];
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          wen_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_HOLD: begin
        ack_d[gnt_q] = 1'b1;
        ce_d  = 1'b1;
        ub_d  = 1'b1;
        lb_d  = 1'b1;
        doe_d = 1'b0;
      end
      default: begin
        ce_d  = 1'b1;
        oe_d  = 1'b1;
        wen_d = 1'b1;
        ub_d  = 1'b1;
        lb_d  = 1'b1;
        doe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      cmd_q   <= '0;
      gnt_q   <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      wen_q   <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      doe_q   <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      gnt_q   <= gnt_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      wen_q   <= wen_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      doe_q   <= doe_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
`ifdef SRAM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign Data   = doe_q ? cmd_q.wdata : {DATA_W{1'bz}};
  assign ADDR   = cmd_q.addr;
  assign CE     = ce_q;
  assign OE     = oe_q;
  assign WE     = wen_q;
  assign UB     = ub_q;
  assign LB     = lb_q;
  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_q;

  a_oe_we_excl: assert property (@(posedge Clk) disable iff (Reset) !(!oe_q && !wen_q));
  a_no_drive_on_read: assert property (@(posedge Clk) disable iff (Reset) !(doe_q && !oe_q));

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single off-chip 16-bit asynchronous SRAM (CE/UB/LB/OE/WE active-low, 20-bit ADDR, bidirectional Data) between two requesters.
- Port 0 is the SLC-3 CPU memory interface. Port 1 is the program loader/debug DMA.
- Sequences each access as a multi-cycle SRAM read or write with fixed timing.
- Sits between slc3 and the top-level SRAM pins; in simulation, test_memory sits on those pins.

Parameters:
- WAIT_CYCLES, 2: number of cycles OE (read) or WE (write) is held low. Must be >= 1; elaboration assertion otherwise.
- ADDR_W, 20: SRAM address width.
- DATA_W, 16: SRAM data width.

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- req  in  2  per-port request; bit i = port i
- we  in  2  per-port write enable (1 = write, 0 = read)
- addr  in  2*ADDR_W  packed per-port address; port i at [i*ADDR_W +: ADDR_W]
- wdata  in  2*DATA_W  packed per-port write data
- be  in  4  packed per-port byte enables; [1] = upper byte, [0] = lower byte
- ack  out  2  one-cycle completion pulse per port
- rdata  out  DATA_W  read data, valid while ack is high
- busy  out  1  high in any state other than IDLE
- gnt_id  out  1  index of the port currently being served
- CE, UB, LB, OE, WE  out  1 each  SRAM controls, active-low
- ADDR  out  ADDR_W  SRAM address
- Data  inout  DATA_W  SRAM data bus, tri-stated unless writing

Behaviour:
- All outputs are registered. The only exception is Data, which is driven from the registered write data under a registered output-enable.
- Reset values: CE=UB=LB=OE=WE=1, ADDR=0, Data=Z, ack=0, rdata=0, busy=0, gnt_id=0, state IDLE, RR pointer=0.
- Requester protocol:
  - Hold req/we/addr/wdata/be stable from assertion until ack is seen.
  - Drop req on the edge following ack, or keep it high to issue a new access.
  - The arbiter latches the command at grant, so later changes are ignored.
  - A granted access always completes.
- FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, RECOVER.
- IDLE:
  - If no req, stay.
  - Otherwise pick a winner, latch its command and set gnt_id.
  - Drive ADDR=addr, CE=0, UB=~be[1], LB=~be[0].
  - Read: OE=0, go to READ. Write: go to WR_SETUP.
- READ:
  - Lasts WAIT_CYCLES cycles (down-counter).
  - On the last cycle, register rdata<=Data and ack[gnt_id]<=1.
  - Raise CE/OE/UB/LB, then go to RECOVER.
- WR_SETUP (1 cycle): enable the Data driver with wdata; WE stays 1 for address setup.
- WR_PULSE: WE=0 for WAIT_CYCLES cycles.
- WR_HOLD (1 cycle): WE=1; keep Data, ADDR and CE driven; set ack[gnt_id]<=1 for the next cycle.
- RECOVER (1 cycle):
  - All controls high, Data=Z, ack high, busy still 1.
  - Then go to IDLE.
  - The next grant can occur in the following IDLE cycle.
- Latency, with req seen in IDLE at cycle T:
  - Read: ack in cycle T+1+WAIT_CYCLES.
  - Write: ack in cycle T+3+WAIT_CYCLES.
  - Minimum spacing between grants is WAIT_CYCLES+2 cycles (read) or WAIT_CYCLES+4 cycles (write).
- Arbitration without the optional feature: fixed priority, port 0 wins simultaneous requests.
- Bus discipline:
  - Data is driven only in WR_SETUP, WR_PULSE and WR_HOLD.
  - OE and WE are never both 0.
  - Data is never driven while OE=0.
- be=2'b00: the cycle still runs with UB=LB=1, and ack is still given. Reads return the unmasked bus value (rdata is never byte-masked).
- ADDR wraps naturally; no range checking.
- Reset mid-operation: controls go high and Data=Z immediately (asynchronous). ack is cleared, the transaction is dropped, and the FSM returns to IDLE.

Optional Feature:
- SRAM_ARB_RR_EN defined: round-robin arbitration.
  - A one-bit pointer names the preferred port.
  - After each grant, the pointer becomes the other port.
  - Simultaneous requests alternate, so neither port starves.
- Undefined: fixed priority with port 0 (CPU) highest; the pointer logic is absent.

Decomposition:
- Package sram_arb_pkg holds:
  - state_t enum for the six states;
  - constants PORT_CPU=0, PORT_DMA=1, ADDR_W, DATA_W;
  - typedef cmd_t {we, addr, wdata, be} for the latched command.
- One sub-module, sram_arb_pick: combinational winner select from req and the pointer. Outputs grant valid and winner index; includes the RR/fixed `ifdef.

Test Plan:
- Assert Reset during READ with WAIT_CYCLES=2 -> same cycle: CE=OE=WE=UB=LB=1, Data=Z, ack=0; after release, busy=0.
- Port 0 read of 0x00010 with memory=0xBEEF, be=11 -> CE/OE low exactly 2 cycles; ack[0] in T+3 with rdata=0xBEEF; WE stays 1 throughout.
- Port 1 write of 0x0003F, wdata=0x1234, be=01 -> LB=0, UB=1; WE low exactly 2 cycles; Data=0x1234 over 4 cycles; ack[1] at T+5. A port 0 readback gives low byte 0x34 and an unchanged upper byte.
- Both ports request reads on the same cycle, held for 3 transactions each -> fixed: all port 0 grants first. SRAM_ARB_RR_EN: grant order 0,1,0,1,0,1.
- Port 0 keeps req high with we toggling -> OE and WE are never low together, and Data stays Z whenever OE=0 (checked by assertion every cycle).
